x_div_seq: RTL and testbench



---
 rtl/x_div_seq_if.sv | 25 ++
 rtl/x_div_seq.sv | 177 +++++++++++++++++
 tb/tb_x_div_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/x_div_seq_if.sv
// Operand/result bundle for the sequential divider: start/busy/result_valid
// handshake plus operands and held results.
interface x_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, result_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, result_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/x_div_seq.sv
// Multi-cycle restoring divider, STEPS subtract/compare/restore steps per clock
// over a shared remainder:quotient register, with signed mode and divide-by-zero.
module x_div_seq #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    x_div_seq_if.slave  bus
);
    localparam int NITER = WIDTH / STEPS;
    localparam int CW    = $clog2(NITER + 1);

    if (((WIDTH % STEPS) != 0) || (WIDTH < 4)) begin : g_param_check
        $error("x_div_seq: STEPS must divide WIDTH exactly and WIDTH must be >= 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] rq_q, rq_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;

    logic               dvd_neg_s, dvs_neg_s, dvsr_zero_s;

    // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        if (neg) begin
            mag = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag = v;
        end
    endfunction

    // The top bit shifted out is always 0: the upper half stays below 2^(WIDTH-1)
    // until the final step, so a WIDTH+1-bit difference is enough.
    function automatic logic [2*WIDTH-1:0] restore_steps(input logic [2*WIDTH-1:0] rq_in,
                                                         input logic [WIDTH-1:0]   d);
        logic [2*WIDTH-1:0] rq;
        logic [WIDTH:0]     diff;
        rq = rq_in;
        for (int i = 0; i < STEPS; i++) begin
            rq   = {rq[2*WIDTH-2:0], 1'b0};
            diff = {1'b0, rq[2*WIDTH-1:WIDTH]} - {1'b0, d};
            if (!diff[WIDTH]) begin
                rq[2*WIDTH-1:WIDTH] = diff[WIDTH-1:0];
                rq[0]               = 1'b1;
            end else begin
                rq[0] = 1'b0;
            end
        end
        restore_steps = rq;
    endfunction

    assign dvd_neg_s   = bus.is_signed & bus.dividend[WIDTH-1];
    assign dvs_neg_s   = bus.is_signed & bus.divisor[WIDTH-1];
    assign dvsr_zero_s = (bus.divisor == {WIDTH{1'b0}});

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            rq_q    <= {(2*WIDTH){1'b0}};
            dvsr_q  <= {WIDTH{1'b0}};
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rq_q    <= rq_d;
            dvsr_q  <= dvsr_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            dbz_q   <= dbz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start && dvsr_zero_s) begin
                    state_d = ST_DONE;
                end else if (bus.start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIX:  state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; results only change on entry to DONE.
    always_comb begin
        cnt_d  = cnt_q;
        rq_d   = rq_q;
        dvsr_d = dvsr_q;
        negq_d = negq_q;
        negr_d = negr_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    rq_d   = {{WIDTH{1'b0}}, mag(bus.dividend, dvd_neg_s)};
                    dvsr_d = mag(bus.divisor, dvs_neg_s);
                    cnt_d  = CW'(NITER);
                    negq_d = dvd_neg_s ^ dvs_neg_s;
                    negr_d = dvd_neg_s;
                    if (dvsr_zero_s) begin
                        quo_d = {WIDTH{1'b0}};
                        rem_d = {WIDTH{1'b0}};
                        dbz_d = 1'b1;
                    end else begin
                        dbz_d = dbz_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RUN: begin
                rq_d  = restore_steps(rq_q, dvsr_q);
                cnt_d = cnt_q - CW'(1);
            end
            ST_FIX: begin
                quo_d = mag(rq_q[WIDTH-1:0], negq_q);
                rem_d = mag(rq_q[2*WIDTH-1:WIDTH], negr_q);
                dbz_d = 1'b0;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
        busy_d  = (state_d == ST_RUN) || (state_d == ST_FIX);
        valid_d = (state_d == ST_DONE);
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = valid_q;
    assign bus.quotient     = quo_q;
    assign bus.remainder    = rem_q;
    assign bus.div_by_zero  = dbz_q;
endmodule

// File: tb/tb_x_div_seq.sv
// Directed and reference-model checks for x_div_seq at WIDTH=32/STEPS=1 and
// WIDTH=16/STEPS=4.
module tb_x_div_seq;
    logic clock = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    x_div_seq_if #(.WIDTH(32)) bus32();
    x_div_seq_if #(.WIDTH(16)) bus16();

    x_div_seq #(.WIDTH(32), .STEPS(1)) u_dut32 (.clock(clock), .reset_n(reset_n), .bus(bus32));
    x_div_seq #(.WIDTH(16), .STEPS(4)) u_dut16 (.clock(clock), .reset_n(reset_n), .bus(bus16));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus32.start     = 1'b1;
        bus32.is_signed = sgn;
        bus32.dividend  = a;
        bus32.divisor   = b;
    endtask

    // Start must already be driven; the first edge here is the sampling edge.
    task automatic wait32(input string tag, input logic [31:0] eq, input logic [31:0] er,
                          input logic ez, input int eedges, input int poke_at);
        int n;
        int nbusy;
        @(posedge clock); #1;
        bus32.start = 1'b0;
        n     = 0;
        nbusy = 0;
        while (!bus32.result_valid && n < 100) begin
            if (bus32.busy) nbusy++;
            if (n == poke_at) start32(1'b0, 32'd77, 32'd3);
            else bus32.start = 1'b0;
            @(posedge clock); #1;
            n++;
        end
        check({tag, ".valid"}, 32'(bus32.result_valid), 32'd1);
        check({tag, ".edges"}, n, eedges);
        check({tag, ".busy_cycles"}, nbusy, eedges);
        check({tag, ".q"}, bus32.quotient, eq);
        check({tag, ".r"}, bus32.remainder, er);
        check({tag, ".dbz"}, 32'(bus32.div_by_zero), 32'(ez));
    endtask

    task automatic op32(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input logic ez, input int eedges);
        @(negedge clock);
        start32(sgn, a, b);
        wait32(tag, eq, er, ez, eedges, -1);
        @(posedge clock); #1;
        check({tag, ".pulse_end"}, 32'(bus32.result_valid), 32'd0);
    endtask

    task automatic run16(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic z,
                         output logic v, output int n);
        @(negedge clock);
        bus16.start     = 1'b1;
        bus16.is_signed = sgn;
        bus16.dividend  = a;
        bus16.divisor   = b;
        @(posedge clock); #1;
        bus16.start = 1'b0;
        n = 0;
        while (!bus16.result_valid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        v = bus16.result_valid;
        q = bus16.quotient;
        r = bus16.remainder;
        z = bus16.div_by_zero;
    endtask

    function automatic void model16(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output logic z);
        int sa;
        int sb;
        if (b == 16'd0) begin
            q = 16'd0; r = 16'd0; z = 1'b1;
        end else if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 16'(sa / sb);
            r  = 16'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a, b, q, r, eq, er;
        logic        z, ez, v;
        int          n, seen;

        reset_n = 1'b0;
        bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.dividend = 32'd0; bus32.divisor = 32'd0;
        bus16.start = 1'b0; bus16.is_signed = 1'b0; bus16.dividend = 16'd0; bus16.divisor = 16'd0;
        #2;
        check("rst.busy",  32'(bus32.busy), 32'd0);
        check("rst.valid", 32'(bus32.result_valid), 32'd0);
        check("rst.q",     bus32.quotient, 32'd0);
        check("rst.r",     bus32.remainder, 32'd0);
        check("rst.dbz",   32'(bus32.div_by_zero), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        op32("u100_7",   1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        1'b0, 33);
        op32("s-100_7",  1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2,  32'hFFFFFFFE, 1'b0, 33);
        op32("s100_-7",  1'b1, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2,  32'd2,        1'b0, 33);
        op32("s_ovf",    1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0,        1'b0, 33);
        op32("s-7_-2",   1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,         32'hFFFFFFFF, 1'b0, 33);
        op32("dbz55",    1'b0, 32'd55,         32'd0,        32'd0,         32'd0,        1'b1, 0);
        op32("u9_3",     1'b0, 32'd9,          32'd3,        32'd3,         32'd0,        1'b0, 33);
        op32("uFFFF_1",  1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0,        1'b0, 33);
        op32("uFFFE_FF", 1'b0, 32'hFFFFFFFE,   32'hFFFFFFFF, 32'd0,         32'hFFFFFFFE, 1'b0, 33);
        op32("s7_-2",    1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,        1'b0, 33);

        // start pulsed mid-RUN must be ignored
        @(negedge clock);
        start32(1'b0, 32'd1000, 32'd10);
        wait32("ignore", 32'd100, 32'd0, 1'b0, 33, 5);
        @(posedge clock); #1;
        check("ignore.pulse_end", 32'(bus32.result_valid), 32'd0);

        // back-to-back starts issued in the DONE cycle
        @(negedge clock);
        start32(1'b1, 32'hFFFFFFF9, 32'd2);
        wait32("b2b0", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33, -1);
        start32(1'b0, 32'd1000, 32'd7);
        wait32("b2b1", 32'd142, 32'd6, 1'b0, 33, -1);
        start32(1'b0, 32'd5, 32'd0);
        wait32("b2b2", 32'd0, 32'd0, 1'b1, 0, -1);
        start32(1'b0, 32'd20, 32'd6);
        wait32("b2b3", 32'd3, 32'd2, 1'b0, 33, -1);
        @(posedge clock); #1;
        check("b2b.pulse_end", 32'(bus32.result_valid), 32'd0);

        // asynchronous reset between edges during RUN
        @(negedge clock);
        start32(1'b0, 32'd100, 32'd7);
        @(posedge clock); #1;
        bus32.start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        check("arst.busy_before", 32'(bus32.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst.busy",  32'(bus32.busy), 32'd0);
        check("arst.valid", 32'(bus32.result_valid), 32'd0);
        check("arst.q",     bus32.quotient, 32'd0);
        check("arst.r",     bus32.remainder, 32'd0);
        check("arst.dbz",   32'(bus32.div_by_zero), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (bus32.result_valid || bus32.busy) seen++;
        end
        check("arst.no_result", seen, 32'd0);
        op32("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);

        // WIDTH=16, STEPS=4 directed
        run16(1'b0, 16'hFFFF, 16'h0003, q, r, z, v, n);
        check("w16.valid", 32'(v), 32'd1);
        check("w16.edges", n, 32'd5);
        check("w16.q", 32'(q), 32'h5555);
        check("w16.r", 32'(r), 32'd0);
        check("w16.dbz", 32'(z), 32'd0);

        // WIDTH=16, STEPS=4 against the reference model, unsigned then signed
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 1000; k++) begin
                a = 16'($urandom);
                b = 16'($urandom);
                case ($urandom_range(0, 7))
                    0: b = 16'd0;
                    1: b = 16'hFFFF;
                    2: a = 16'h8000;
                    3: b = 16'd1;
                    default: a = a;
                endcase
                model16(m[0], a, b, eq, er, ez);
                run16(m[0], a, b, q, r, z, v, n);
                check("rnd.valid", 32'(v), 32'd1);
                check("rnd.edges", n, (ez ? 32'd0 : 32'd5));
                check("rnd.q", 32'(q), 32'(eq));
                check("rnd.r", 32'(r), 32'(er));
                check("rnd.dbz", 32'(z), 32'(ez));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
